// File: rtl/text_pkg.sv
// ============================================================================
// Module  : text_pkg
// Purpose : Shared state encoding, character constants and mapper field
//           positions for line_streamer.
//           LINE_STREAMER_CRLF_EN adds the EOL_CR and EOL_LF states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package text_pkg;

`ifdef LINE_STREAMER_CRLF_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_EMIT_HI = 3'd3,
        ST_EMIT_LO = 3'd4,
        ST_DONE    = 3'd5,
        ST_EOL_CR  = 3'd6,
        ST_EOL_LF  = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_EMIT_HI = 3'd3,
        ST_EMIT_LO = 3'd4,
        ST_DONE    = 3'd5
    } state_t;
`endif

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    localparam int LEN_MSB   = 15;
    localparam int LEN_LSB   = 8;
    localparam int START_MSB = 7;
    localparam int START_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/line_streamer.sv
// ============================================================================
// Module  : line_streamer
// Purpose : Looks up a line through the mapper, walks its ROM words and
//           streams two characters per word on a valid/ready interface.
//           Define LINE_STREAMER_CRLF_EN to append CR/LF to non-empty lines.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module line_streamer
    import text_pkg::*;
#(
    parameter int unsigned NUM_LINES = 10,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        line_sel,
    output logic [7:0]        map_line,
    input  logic [15:0]       map_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [7:0]        map_line_q, map_line_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [7:0]        lo_char_q, lo_char_d;
    logic [7:0]        char_out_q, char_out_d;
    logic              char_valid_q, char_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hs;

    assign hs = char_valid_q && char_ready;

    always_comb begin
        state_d      = state_q;
        map_line_d   = map_line_q;
        rom_addr_d   = rom_addr_q;
        len_d        = len_q;
        lo_char_d    = lo_char_q;
        char_out_d   = char_out_q;
        char_valid_d = char_valid_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (32'(line_sel) < NUM_LINES) begin
                        map_line_d = line_sel;
                        state_d    = ST_LOOKUP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOOKUP: begin
                len_d      = ADDR_W'(map_addr[LEN_MSB:LEN_LSB]);
                rom_addr_d = ADDR_W'(map_addr[START_MSB:START_LSB]);
                state_d    = (map_addr[LEN_MSB:LEN_LSB] == 8'd0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                lo_char_d    = rom_data[7:0];
                char_out_d   = rom_data[15:8];
                char_valid_d = 1'b1;
                state_d      = ST_EMIT_HI;
            end
            ST_EMIT_HI: begin
                if (hs) begin
                    char_out_d = lo_char_q;
                    state_d    = ST_EMIT_LO;
                end
            end
            ST_EMIT_LO: begin
                if (hs) begin
                    len_d      = len_q - 1'b1;
                    rom_addr_d = rom_addr_q + 1'b1;
                    if (len_q == ADDR_W'(1)) begin
`ifdef LINE_STREAMER_CRLF_EN
                        char_out_d = CHAR_CR;
                        state_d    = ST_EOL_CR;
`else
                        char_valid_d = 1'b0;
                        state_d      = ST_DONE;
`endif
                    end else begin
                        char_valid_d = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end
            end
`ifdef LINE_STREAMER_CRLF_EN
            ST_EOL_CR: begin
                if (hs) begin
                    char_out_d = CHAR_LF;
                    state_d    = ST_EOL_LF;
                end
            end
            ST_EOL_LF: begin
                if (hs) begin
                    char_valid_d = 1'b0;
                    state_d      = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                char_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        // Status flags are registered views of the state being entered.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            map_line_q   <= '0;
            rom_addr_q   <= '0;
            len_q        <= '0;
            lo_char_q    <= '0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            map_line_q   <= map_line_d;
            rom_addr_q   <= rom_addr_d;
            len_q        <= len_d;
            lo_char_q    <= lo_char_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign map_line   = map_line_q;
    assign rom_addr   = rom_addr_q;
    assign char_out   = char_out_q;
    assign char_valid = char_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_line_streamer.sv
// ============================================================================
// Module  : tb_line_streamer
// Purpose : Directed self-checking bench for line_streamer with behavioural
//           mapper and ROM models. Honours LINE_STREAMER_CRLF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_streamer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  line_sel;
    logic [7:0]  map_line;
    logic [15:0] map_addr;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] map_tab [256];
    logic [15:0] rom_tab [256];

    assign map_addr = map_tab[map_line];
    assign rom_data = rom_tab[rom_addr];

    line_streamer #(.NUM_LINES(10), .ADDR_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .line_sel   (line_sel),
        .map_line   (map_line),
        .map_addr   (map_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    logic [7:0] got_q   [$];
    logic [7:0] addr_q  [$];
    logic [7:0] exp_q   [$];
    int first_valid_c;
    int done_c;
    int done_cnt;
    int err_cnt;

    // Streams one line; the consumer stalls stall_len cycles on stall_char.
    task automatic run_line(input logic [7:0] sel, input logic [7:0] stall_char, input int stall_len);
        int c, stalls;
        logic pv, pr;
        logic [7:0] pc;
        got_q.delete();
        addr_q.delete();
        first_valid_c = -1;
        done_c = -1;
        done_cnt = 0;
        err_cnt = 0;
        c = 0; stalls = 0; pv = 1'b0; pr = 1'b1; pc = 8'h00;
        @(negedge clk);
        start = 1'b1;
        line_sel = sel;
        char_ready = 1'b1;
        while (c < 200 && !(done_c >= 0 && c >= done_c + 2)) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (pv && !pr) begin
                check("hold_valid", 32'(char_valid), 32'd1);
                check("hold_char", 32'(char_out), 32'(pc));
            end
            if (char_valid && first_valid_c < 0) first_valid_c = c;
            if (char_valid && char_out == stall_char && stalls < stall_len) begin
                char_ready = 1'b0;
                stalls++;
            end else begin
                char_ready = 1'b1;
            end
            if (char_valid && char_ready) begin
                got_q.push_back(char_out);
                addr_q.push_back(rom_addr);
            end
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
                if (err) err_cnt++;
            end
            pv = char_valid; pr = char_ready; pc = char_out;
        end
        check("done_seen", 32'(done_c >= 0), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_char%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic set_expected(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c2,
                                input logic [7:0] d, input logic [7:0] e, input logic [7:0] f);
        exp_q.delete();
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c2);
        exp_q.push_back(d); exp_q.push_back(e); exp_q.push_back(f);
`ifdef LINE_STREAMER_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            map_tab[i] = 16'h0000;
            rom_tab[i] = 16'h0000;
        end
        map_tab[0] = 16'h0300;
        map_tab[1] = 16'h0007;
        map_tab[2] = 16'h03FE;
        rom_tab[8'h00] = 16'h3131;
        rom_tab[8'h01] = 16'h4142;
        rom_tab[8'h02] = 16'h7320;
        rom_tab[8'hFE] = 16'h5051;
        rom_tab[8'hFF] = 16'h5253;

        rst_n = 1'b0; start = 1'b0; line_sel = 8'd0; char_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_map_line", 32'(map_line), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_char_out", 32'(char_out), 32'd0);
        check("rst_valid", 32'(char_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal line
        set_expected(8'h31, 8'h31, 8'h41, 8'h42, 8'h73, 8'h20);
        run_line(8'd0, 8'h00, 0);
        compare_stream("nom");
        check("nom_first_valid", 32'(first_valid_c), 32'd3);
        check("nom_done_cnt", 32'(done_cnt), 32'd1);
        check("nom_err", 32'(err_cnt), 32'd0);
`ifdef LINE_STREAMER_CRLF_EN
        check("nom_done_cycle", 32'(done_c), 32'd13);
`else
        check("nom_done_cycle", 32'(done_c), 32'd11);
`endif

        // Backpressure on 0x41
        run_line(8'd0, 8'h41, 5);
        compare_stream("bp");
        check("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Empty line
        exp_q.delete();
        run_line(8'd1, 8'h00, 0);
        check("empty_count", 32'(got_q.size()), 32'd0);
        check("empty_no_valid", 32'(first_valid_c), 32'hFFFF_FFFF);
        check("empty_done_cycle", 32'(done_c), 32'd2);
        check("empty_err", 32'(err_cnt), 32'd0);

        // Address wrap
        set_expected(8'h50, 8'h51, 8'h52, 8'h53, 8'h31, 8'h31);
        run_line(8'd2, 8'h00, 0);
        compare_stream("wrap");
        if (addr_q.size() >= 5) begin
            check("wrap_addr0", 32'(addr_q[0]), 32'h00FE);
            check("wrap_addr1", 32'(addr_q[2]), 32'h00FF);
            check("wrap_addr2", 32'(addr_q[4]), 32'h0000);
        end else begin
            check("wrap_addr_count", 32'(addr_q.size()), 32'd6);
        end

        // Out-of-range line
        run_line(8'd12, 8'h00, 0);
        check("rej_done_cycle", 32'(done_c), 32'd1);
        check("rej_done_cnt", 32'(done_cnt), 32'd1);
        check("rej_err", 32'(err_cnt), 32'd1);
        check("rej_count", 32'(got_q.size()), 32'd0);
        check("rej_map_line", 32'(map_line), 32'd2);

        // Reset during EMIT_LO of the first word
        @(negedge clk);
        start = 1'b1; line_sel = 8'd0; char_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_valid", 32'(char_valid), 32'd1);
        check("mid_char", 32'(char_out), 32'h31);
        #2 rst_n = 1'b0;
        #1;
        check("arst_map_line", 32'(map_line), 32'd0);
        check("arst_rom_addr", 32'(rom_addr), 32'd0);
        check("arst_char_out", 32'(char_out), 32'd0);
        check("arst_valid", 32'(char_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_hold_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        set_expected(8'h31, 8'h31, 8'h41, 8'h42, 8'h73, 8'h20);
        run_line(8'd0, 8'h00, 0);
        compare_stream("restart");
        check("restart_first_valid", 32'(first_valid_c), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/line_streamer.md
Name: line_streamer

Overview:
- Sequencer between the line-index mapper and the packed character ROM.
- On a start request it:
  - drives the line number to the mapper and latches the {length, start} word it returns;
  - walks the ROM word addresses for that line;
  - unpacks each 16-bit word into two 8-bit characters and streams them out on a valid/ready interface.
- Typical consumer: a UART or display shifter.
- Mapper and ROM are combinational lookups outside this block.

Parameters:
- NUM_LINES, 10, number of valid line indices; line_sel >= NUM_LINES is rejected.
- ADDR_W, 8, ROM word-address width; also the width of the length field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to stream line_sel; sampled only in IDLE
- line_sel  in  8  line index to stream
- map_line  out  8  line index driven to the mapper
- map_addr  in  16  mapper result: [15:8] length in words, [7:0] start word address
- rom_addr  out  ADDR_W  word address driven to the ROM
- rom_data  in  16  ROM word: [15:8] first char, [7:0] second char
- char_out  out  8  streamed character
- char_valid  out  1  char_out holds a character
- char_ready  in  1  consumer accepts when char_valid && char_ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a line completes or is rejected
- err  out  1  one-cycle pulse, coincident with done, for out-of-range line_sel

Behaviour:
- Clock and reset: the single clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values (all registered): map_line=0, rom_addr=0, char_out=0, char_valid=0, busy=0, done=0, err=0; state=IDLE.
- Reset mid-line aborts immediately; no done pulse is produced.
- States: IDLE, LOOKUP, FETCH, EMIT_HI, EMIT_LO, DONE.
- IDLE:
  - start=1 and line_sel < NUM_LINES: latch map_line=line_sel, go to LOOKUP.
  - start=1 and line_sel >= NUM_LINES: go to DONE with err flagged.
  - start is ignored in all other states.
- LOOKUP:
  - latch len=map_addr[15:8]; set rom_addr=map_addr[7:0].
  - len==0: go to DONE.
  - otherwise go to FETCH.
- FETCH:
  - latch rom_data into the word register.
  - set char_out=word[15:8] and char_valid=1; go to EMIT_HI.
- EMIT_HI: on handshake, char_out=word[7:0] with char_valid held high; go to EMIT_LO.
- EMIT_LO: on handshake, decrement len and increment rom_addr (mod 2^ADDR_W, so 0xFF wraps to 0x00).
  - remaining len==0: char_valid=0, go to DONE.
  - otherwise char_valid=0, go to FETCH.
- DONE: done=1 (and err if flagged) for exactly one cycle, then IDLE. busy stays high through DONE.
- Handshake rules:
  - char_out is stable while char_valid && !char_ready.
  - char_valid never drops without a handshake, except on reset.
- Throughput and latency:
  - 3 cycles per word with char_ready held high.
  - First char_valid appears 3 cycles after start is sampled.
- Padding characters (0x20) are streamed like any other character.

Optional Feature:
- Macro LINE_STREAMER_CRLF_EN.
- Defined:
  - after the last EMIT_LO handshake of a non-empty line, states EOL_CR and EOL_LF emit 0x0D then 0x0A under the same handshake rules, before DONE.
  - rejected lines and len==0 lines emit nothing extra.
- Undefined: no extra states; the line ends on the last ROM character.

Decomposition:
- Shared package text_pkg holds:
  - state enum;
  - CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_SP=8'h20;
  - field positions LEN_MSB=15, LEN_LSB=8, START_MSB=7, START_LSB=0.
- No sub-module. A single FSM with a datapath of word, len and rom_addr registers is natural.
- The bench instantiates the existing mapper and ROM, or behavioural models of them.

Test Plan:
- Nominal line:
  - Stimulus: line_sel=0; map model returns 0x0300; ROM[0..2]=0x3131,0x4142,0x7320; char_ready=1.
  - Response: chars 31,31,41,42,73,20 in order; first valid 3 cycles after start; done pulse once; err=0.
- Backpressure:
  - Stimulus: same line, char_ready low for 5 cycles while char_out=0x41.
  - Response: char_valid=1 and char_out=0x41 stable throughout; no character lost or duplicated.
- Empty and out-of-range lines:
  - Stimulus: map returns 0x0007 (len 0).
  - Response: no char_valid; done 2 cycles after start.
  - Stimulus: line_sel=12.
  - Response: done=err=1 one cycle after start; map_line unchanged.
- Address wrap:
  - Stimulus: map returns 0x03FE.
  - Response: rom_addr sequence FE, FF, 00; 6 chars streamed.
- Reset mid-line:
  - Stimulus: assert rst_n=0 during EMIT_LO.
  - Response: all outputs 0 asynchronously; no done pulse; the next start streams from the first char.
- CRLF:
  - Stimulus: nominal line with LINE_STREAMER_CRLF_EN defined.
  - Response: stream ends 20,0D,0A then done. For len 0, no CR/LF.
